fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory and downstream-feeding decode. Owns the program counter, drives the instruction-memory word address from a registered PC (memory samples it on the falling edge), captures the returned instruction into a registered fetch/decode slot with a valid/ready handshake, and handles redirects (branch/jump), halt and post-reset boot sequencing. Uses the `wi23_defs` package widths.

---
 rtl/wi23_defs.sv | 5 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wi23_defs.sv
// Shared widths for the wi23 core: instruction/PC width and instruction-memory address width.
package wi23_defs;
    localparam int unsigned PC_WIDTH   = 16;
    localparam int unsigned IMEM_DEPTH = 10;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction-memory port plus the fetch/decode slot handshake.
interface fetch_unit_if;
    import wi23_defs::*;

    logic [IMEM_DEPTH-1:0] imem_addr_o;
    logic [PC_WIDTH-1:0]   imem_inst_i;
    logic                  if_valid_o;
    logic                  if_ready_i;
    logic [PC_WIDTH-1:0]   if_inst_o;
    logic [PC_WIDTH-1:0]   if_pc_o;
    logic [PC_WIDTH-1:0]   if_pc_next_o;

    modport master (
        output imem_addr_o,
        input  imem_inst_i,
        output if_valid_o,
        input  if_ready_i,
        output if_inst_o,
        output if_pc_o,
        output if_pc_next_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_inst_i,
        input  if_valid_o,
        output if_ready_i,
        input  if_inst_o,
        input  if_pc_o,
        input  if_pc_next_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory, fills the decode slot.
// Optional FETCH_PERF_EN adds fetch/stall performance counters.
module fetch_unit
    import wi23_defs::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        bus,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                halt_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_o,
    output logic [31:0]         perf_stall_o
`endif
);

    localparam logic [PC_WIDTH-1:0] PC_LSB_CLR = ~PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(2);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [PC_WIDTH-1:0] inst_q, inst_d;
    logic [PC_WIDTH-1:0] ipc_q, ipc_d;
    logic [PC_WIDTH-1:0] ipc_next_q, ipc_next_d;
    logic                stalled;
    logic                capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC & PC_LSB_CLR;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            ipc_q      <= '0;
            ipc_next_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            ipc_q      <= ipc_d;
            ipc_next_q <= ipc_next_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        ipc_d      = ipc_q;
        ipc_next_d = ipc_next_q;
        stalled    = valid_q && !bus.if_ready_i;
        capture    = 1'b0;

        // Redirect outranks halt, stall and capture, and always resumes in RUN.
        if (redirect_i) begin
            pc_d    = redirect_pc_i & PC_LSB_CLR;
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (halt_i) begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end else if (!stalled) begin
                        capture = 1'b1;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end

        if (capture) begin
            inst_d     = bus.imem_inst_i;
            ipc_d      = pc_q;
            ipc_next_d = pc_q + PC_STEP;
            valid_d    = 1'b1;
            pc_d       = pc_q + PC_STEP;
        end
    end

    // Memory samples the address on the falling edge, so it comes from the register only.
    assign bus.imem_addr_o  = pc_q[IMEM_DEPTH:1];
    assign bus.if_valid_o   = valid_q;
    assign bus.if_inst_o    = inst_q;
    assign bus.if_pc_o      = ipc_q;
    assign bus.if_pc_next_o = ipc_next_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (capture) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (state_q == RUN && stalled) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_unit;
    import wi23_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] mem [1024];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus1 ();
    fetch_unit_if bus2 ();

    assign bus2.if_ready_i = 1'b1;

    // Memory latches the word address on the falling edge.
    always @(negedge clk) begin
        bus1.imem_inst_i <= mem[bus1.imem_addr_o];
        bus2.imem_inst_i <= mem[bus2.imem_addr_o];
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch1, perf_stall1, perf_fetch2, perf_stall2;
`endif

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus1),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halt_i       (halt)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o (perf_fetch1),
        .perf_stall_o (perf_stall1)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus2),
        .redirect_i   (1'b0),
        .redirect_pc_i(16'h0000),
        .halt_i       (1'b0)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o (perf_fetch2),
        .perf_stall_o (perf_stall2)
`endif
    );

    // Reference model of the main DUT: mode 0 = waiting out boot, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [15:0] m_pc, m_inst, m_ipc;
    logic        m_valid;
    logic [31:0] m_fetch, m_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_pc    <= 16'h0000;
            m_valid <= 1'b0;
            m_inst  <= 16'h0000;
            m_ipc   <= 16'h0000;
            m_fetch <= 0;
            m_stall <= 0;
        end else begin
            if (m_mode == 1 && m_valid && !bus1.if_ready_i) m_stall <= m_stall + 1;
            if (redirect) begin
                m_pc    <= redirect_pc & 16'hFFFE;
                m_valid <= 1'b0;
                m_mode  <= 1;
            end else if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1) begin
                if (halt) begin
                    m_valid <= 1'b0;
                    m_mode  <= 2;
                end else if (!(m_valid && !bus1.if_ready_i)) begin
                    m_inst  <= mem[m_pc[10:1]];
                    m_ipc   <= m_pc;
                    m_valid <= 1'b1;
                    m_pc    <= m_pc + 16'd2;
                    m_fetch <= m_fetch + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect = 1'b0;
        halt = 1'b0;
        bus1.if_ready_i = 1'b1;
        rst_n = 1'b0;
        #17;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        redirect = 1'b0;
        halt = 1'b0;
        bus1.if_ready_i = 1'b1;
        rst_n = 1'b0;
        #17;
        n_tests++;
        if (bus1.if_valid_o !== 1'b0 || bus1.if_inst_o !== 16'h0 || bus1.if_pc_o !== 16'h0 || bus1.if_pc_next_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_slot: valid=%b inst=%h pc=%h next=%h, required 0/0/0/0", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o, bus1.if_pc_next_o);
        end
        n_tests++;
        if (bus1.imem_addr_o !== 10'd0 || bus2.imem_addr_o !== 10'h3FF) begin
            n_fail++;
            $display("FAIL reset_addr: addr=%h wrap_addr=%h, required 000/3ff", bus1.imem_addr_o, bus2.imem_addr_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_bubble: valid=%b, required 0", bus1.if_valid_o);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h1111 || bus1.if_pc_o !== 16'h0000 || bus1.if_pc_next_o !== 16'h0002) begin
            n_fail++;
            $display("FAIL first_fetch: valid=%b inst=%h pc=%h next=%h, required 1/1111/0000/0002", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o, bus1.if_pc_next_o);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h2222 || bus1.if_pc_o !== 16'h0002) begin
            n_fail++;
            $display("FAIL second_fetch: valid=%b inst=%h pc=%h, required 1/2222/0002", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o);
        end
    endtask

    task automatic test_stall();
        bus1.if_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h2222 || bus1.imem_addr_o !== 10'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b inst=%h addr=%h, required 1/2222/002", i, bus1.if_valid_o, bus1.if_inst_o, bus1.imem_addr_o);
            end
        end
        bus1.if_ready_i = 1'b1;
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h3333 || bus1.if_pc_o !== 16'h0004) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b inst=%h pc=%h, required 1/3333/0004", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h4444 || bus1.if_pc_o !== 16'h0006) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b inst=%h pc=%h, required 1/4444/0006", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o);
        end
    endtask

    task automatic test_redirect_priority();
        bus1.if_ready_i = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'h0011;
        halt = 1'b1;
        tick();
        redirect = 1'b0;
        halt = 1'b0;
        bus1.if_ready_i = 1'b1;
        n_tests++;
        if (bus1.if_valid_o !== 1'b0 || bus1.imem_addr_o !== 10'd8) begin
            n_fail++;
            $display("FAIL redirect_flush: valid=%b addr=%h, required 0/008", bus1.if_valid_o, bus1.imem_addr_o);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== mem[8] || bus1.if_pc_o !== 16'h0010 || bus1.if_pc_next_o !== 16'h0012) begin
            n_fail++;
            $display("FAIL redirect_target: valid=%b inst=%h pc=%h next=%h, required 1/%h/0010/0012", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o, bus1.if_pc_next_o, mem[8]);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_pc_o !== 16'h0012) begin
            n_fail++;
            $display("FAIL redirect_run: valid=%b pc=%h, required 1/0012", bus1.if_valid_o, bus1.if_pc_o);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (bus1.if_valid_o !== 1'b0 || bus1.imem_addr_o !== 10'd10) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: valid=%b addr=%h, required 0/00a", i, bus1.if_valid_o, bus1.imem_addr_o);
            end
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 16'h0004;
        tick();
        redirect = 1'b0;
        n_tests++;
        if (bus1.if_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_resume_bubble: valid=%b, required 0", bus1.if_valid_o);
        end
        tick();
        n_tests++;
        if (bus1.if_valid_o !== 1'b1 || bus1.if_inst_o !== 16'h3333 || bus1.if_pc_o !== 16'h0004) begin
            n_fail++;
            $display("FAIL halt_resume: valid=%b inst=%h pc=%h, required 1/3333/0004", bus1.if_valid_o, bus1.if_inst_o, bus1.if_pc_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        tick();
        n_tests++;
        if (bus2.if_valid_o !== 1'b1 || bus2.if_pc_o !== 16'hFFFE || bus2.if_pc_next_o !== 16'h0000 || bus2.if_inst_o !== mem[1023]) begin
            n_fail++;
            $display("FAIL wrap_first: valid=%b pc=%h next=%h inst=%h, required 1/fffe/0000/%h", bus2.if_valid_o, bus2.if_pc_o, bus2.if_pc_next_o, bus2.if_inst_o, mem[1023]);
        end
        tick();
        n_tests++;
        if (bus2.if_valid_o !== 1'b1 || bus2.if_pc_o !== 16'h0000 || bus2.if_inst_o !== 16'h1111) begin
            n_fail++;
            $display("FAIL wrap_second: valid=%b pc=%h inst=%h, required 1/0000/1111", bus2.if_valid_o, bus2.if_pc_o, bus2.if_inst_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus1.if_ready_i = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 11) == 0);
            redirect_pc = 16'($urandom);
            halt = ($urandom_range(0, 29) == 0);
            tick();
            n_tests++;
            if (bus1.if_valid_o !== m_valid || bus1.imem_addr_o !== m_pc[10:1]) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: valid=%b addr=%h, required %b/%h", i, bus1.if_valid_o, bus1.imem_addr_o, m_valid, m_pc[10:1]);
            end
            if (m_valid) begin
                n_tests++;
                if (bus1.if_inst_o !== m_inst || bus1.if_pc_o !== m_ipc || bus1.if_pc_next_o !== m_ipc + 16'd2) begin
                    n_fail++;
                    $display("FAIL rand_slot[%0d]: inst=%h pc=%h next=%h, required %h/%h/%h", i, bus1.if_inst_o, bus1.if_pc_o, bus1.if_pc_next_o, m_inst, m_ipc, m_ipc + 16'd2);
                end
            end
`ifdef FETCH_PERF_EN
            n_tests++;
            if (perf_fetch1 !== m_fetch || perf_stall1 !== m_stall) begin
                n_fail++;
                $display("FAIL rand_perf[%0d]: fetch=%0d stall=%0d, required %0d/%0d", i, perf_fetch1, perf_stall1, m_fetch, m_stall);
            end
`endif
        end
        redirect = 1'b0;
        halt = 1'b0;
    endtask

    task automatic test_perf();
`ifdef FETCH_PERF_EN
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) tick();
        bus1.if_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (perf_fetch1 !== 32'd5 || perf_stall1 !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_counts: fetch=%0d stall=%0d, required 5/3", perf_fetch1, perf_stall1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (perf_fetch1 !== 32'd0 || perf_stall1 !== 32'd0 || bus1.if_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL perf_async_reset: fetch=%0d stall=%0d valid=%b, required 0/0/0", perf_fetch1, perf_stall1, bus1.if_valid_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus1.if_ready_i = 1'b1;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        bus1.if_ready_i = 1'b1;
        test_reset();
        test_stall();
        test_redirect_priority();
        test_halt();
        test_wrap();
        test_random();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
